vga_rx_grid_capture: RTL

//   Receive end of the 640x480@60 VGA link (RGB111 + active-low H/V sync) on the 25 MHz pixel clock.

---
 rtl/vga_rx_grid_capture_pkg.sv | 20 ++
 rtl/vga_rx_grid_capture_timing.sv | 83 ++++++++
 rtl/vga_rx_grid_capture.sv | 62 ++++++
 3 files changed

// File: rtl/vga_rx_grid_capture_pkg.sv
// vga_rx_grid_capture_pkg: 640x480@60 timing defaults, lock states and cell-centre helpers
package vga_rx_grid_capture_pkg;
  localparam int VGA_H_ACTIVE = 640;
  localparam int VGA_H_FP = 16;
  localparam int VGA_H_SYNC = 96;
  localparam int VGA_H_BP = 48;
  localparam int VGA_V_ACTIVE = 480;
  localparam int VGA_V_FP = 10;
  localparam int VGA_V_SYNC = 2;
  localparam int VGA_V_BP = 33;
  localparam int VGA_H_TOTAL = VGA_H_ACTIVE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;
  localparam int VGA_V_TOTAL = VGA_V_ACTIVE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;
  typedef enum logic [1:0] {SEARCH, MEASURE, LOCKED} lock_state_t;
  function automatic int cell_cx(input int i, input int h_active);
    return h_active / 8 + (h_active / 4) * (i % 4);
  endfunction
  function automatic int cell_cy(input int i, input int v_active);
    return v_active / 4 + (v_active / 2) * (i / 4);
  endfunction
endpackage

// File: rtl/vga_rx_grid_capture_timing.sv
// vga_rx_timing: sync input register, edge detect, h/v counters, lock FSM and error count
module vga_rx_timing
  import vga_rx_grid_capture_pkg::*;
#(
  parameter int H_ACTIVE = VGA_H_ACTIVE,
  parameter int H_FP = VGA_H_FP,
  parameter int H_SYNC = VGA_H_SYNC,
  parameter int H_BP = VGA_H_BP,
  parameter int V_ACTIVE = VGA_V_ACTIVE,
  parameter int V_FP = VGA_V_FP,
  parameter int V_SYNC = VGA_V_SYNC,
  parameter int V_BP = VGA_V_BP,
  parameter int X_OFFSET = 0,
  parameter int LOCK_FRAMES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       hsync_n,
  input  logic       vsync_n,
  output logic       locked,
  output logic       active,
  output logic [9:0] pos_x,
  output logic [8:0] pos_y,
  output logic       vfall,
  output logic       frame_ok,
  output logic [7:0] err_cnt
);
  localparam logic [9:0] H_TOTAL = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP);
  localparam logic [9:0] H_LAST = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [9:0] V_LAST = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam logic [9:0] HS0 = 10'(H_SYNC + H_BP + X_OFFSET);
  localparam logic [9:0] HS1 = 10'(H_SYNC + H_BP + X_OFFSET + H_ACTIVE);
  localparam logic [9:0] VS0 = 10'(V_SYNC + V_BP);
  localparam logic [9:0] VS1 = 10'(V_SYNC + V_BP + V_ACTIVE);
  localparam logic [7:0] LOCK_N = 8'(LOCK_FRAMES);
  logic hs_r, vs_r, hs_d, vs_d, hfall, viol, in_act;
  logic [9:0] h_cnt, v_cnt;
  logic [7:0] good, good_nxt;
  lock_state_t state, state_nxt;
  assign hfall = hs_d & ~hs_r;
  assign vfall = vs_d & ~vs_r;
  assign locked = state == LOCKED;
  assign in_act = h_cnt >= HS0 && h_cnt < HS1 && v_cnt >= VS0 && v_cnt < VS1;
  assign frame_ok = vfall && state == LOCKED && !viol;
  // a line that runs to H_TOTAL without hfall counts once, when h_cnt passes through H_TOTAL
  always_comb begin
    viol = state != SEARCH && ((hfall && h_cnt != H_LAST) || (vfall && v_cnt != V_LAST) || h_cnt == H_TOTAL);
    state_nxt = state;
    good_nxt = good;
    if (viol) state_nxt = SEARCH;
    else if (vfall && state == SEARCH) begin
      state_nxt = MEASURE;
      good_nxt = '0;
    end else if (vfall && state == MEASURE) begin
      good_nxt = good + 8'd1;
      state_nxt = good_nxt == LOCK_N ? LOCKED : MEASURE;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      {hs_r, vs_r, hs_d, vs_d} <= '0;
      h_cnt <= '0;
      v_cnt <= '0;
      state <= SEARCH;
      good <= '0;
      err_cnt <= '0;
      active <= 1'b0;
      pos_x <= '0;
      pos_y <= '0;
    end else begin
      {hs_r, vs_r} <= {hsync_n, vsync_n};
      {hs_d, vs_d} <= {hs_r, vs_r};
      h_cnt <= hfall ? '0 : (&h_cnt ? h_cnt : h_cnt + 10'd1);
      v_cnt <= vfall ? '0 : (hfall && !(&v_cnt) ? v_cnt + 10'd1 : v_cnt);
      state <= state_nxt;
      good <= good_nxt;
      if (viol && !(&err_cnt)) err_cnt <= err_cnt + 8'd1;
      active <= in_act;
      pos_x <= in_act ? h_cnt - HS0 : '0;
      pos_y <= in_act ? 9'(v_cnt - VS0) : '0;
    end
  end
endmodule

// File: rtl/vga_rx_grid_capture.sv
// vga_rx_grid_capture: VGA receive checker sampling the centre pixel of each 4x2 grid cell per good frame
module vga_rx_grid_capture
  import vga_rx_grid_capture_pkg::*;
#(
  parameter int H_ACTIVE = VGA_H_ACTIVE,
  parameter int H_FP = VGA_H_FP,
  parameter int H_SYNC = VGA_H_SYNC,
  parameter int H_BP = VGA_H_BP,
  parameter int V_ACTIVE = VGA_V_ACTIVE,
  parameter int V_FP = VGA_V_FP,
  parameter int V_SYNC = VGA_V_SYNC,
  parameter int V_BP = VGA_V_BP,
  parameter int X_OFFSET = 0,
  parameter int LOCK_FRAMES = 2,
  parameter int DW = 3
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            hsync_n,
  input  logic            vsync_n,
  input  logic [DW-1:0]   rgb,
  output logic            locked,
  output logic            active,
  output logic [9:0]      pos_x,
  output logic [8:0]      pos_y,
  output logic [8*DW-1:0] cells,
  output logic            frame_valid,
  output logic [7:0]      err_cnt
);
  logic vfall, frame_ok;
  logic [7:0] seen, hit;
  logic [8*DW-1:0] shadow;
  logic [DW-1:0] rgb_q [3];
  vga_rx_timing #(
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
    .X_OFFSET(X_OFFSET), .LOCK_FRAMES(LOCK_FRAMES)
  ) u_timing (
    .clk(clk), .rst(rst), .hsync_n(hsync_n), .vsync_n(vsync_n),
    .locked(locked), .active(active), .pos_x(pos_x), .pos_y(pos_y),
    .vfall(vfall), .frame_ok(frame_ok), .err_cnt(err_cnt)
  );
  for (genvar i = 0; i < 8; i++) begin : g_hit
    assign hit[i] = active && pos_x == 10'(cell_cx(i, H_ACTIVE)) && pos_y == 9'(cell_cy(i, V_ACTIVE));
  end
  // rgb_q[2] lines the pixel up with the registered pos_x/pos_y it belongs to
  always_ff @(posedge clk) begin
    if (rst) begin
      rgb_q <= '{default: '0};
      shadow <= '0;
      seen <= '0;
      cells <= '0;
      frame_valid <= 1'b0;
    end else begin
      rgb_q <= '{rgb, rgb_q[0], rgb_q[1]};
      frame_valid <= frame_ok && &seen;
      if (frame_ok && &seen) cells <= shadow;
      seen <= vfall ? '0 : seen | hit;
      for (int i = 0; i < 8; i++) if (hit[i]) shadow[DW*i +: DW] <= rgb_q[2];
    end
  end
endmodule
